// File: rtl/elastic_pipeline_stage.sv
// rtl/elastic_pipeline_stage.sv - one pipeline stage: valid bit plus data register
module elastic_pipeline_stage #(
    parameter int BIT_WIDTH  = 10,
    parameter int RESET_DATA = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 up_valid,
    input  logic [BIT_WIDTH-1:0] up_data,
    output logic                 valid,
    output logic [BIT_WIDTH-1:0] data
);

    // Valid bit: flush wins over load, otherwise take the upstream valid when loading
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
        end
    end

    // Data register keeps its contents across a flush; reset is optional
    if (RESET_DATA != 0) begin : g_data_rst
        // Data with asynchronous clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data <= '0;
            end else if (load && !flush) begin
                data <= up_data;
            end
        end
    end else begin : g_data_norst
        // Data without reset
        always_ff @(posedge clk) begin
            if (load && !flush) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// rtl/elastic_pipeline.sv - elastic register pipeline with backpressure, bubble collapse and flush
module elastic_pipeline #(
    parameter int BIT_WIDTH        = 10,
    parameter int NUMBER_OF_STAGES = 5,
    parameter int RESET_DATA       = 1,
    localparam int OCC_W = (NUMBER_OF_STAGES == 0) ? 1 : $clog2(NUMBER_OF_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]     occupancy
);

    if (NUMBER_OF_STAGES == 0) begin : g_passthru
        // No storage: clock and reset are not needed here
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;

        assign out_valid = in_valid && !flush;
        assign in_ready  = out_ready && !flush;
        assign out_data  = in_data;
        assign occupancy = '0;
    end else begin : g_pipe
        localparam int N = NUMBER_OF_STAGES;

        logic [N-1:0]                stage_valid;
        logic [N-1:0][BIT_WIDTH-1:0] stage_data;
        logic [N-1:0]                advance;
        logic [N-1:0]                load;
        logic [OCC_W-1:0]            pop_count;

        // Advance chain from the output back to the input; an empty stage always loads
        always_comb begin
            advance = '0;
            load    = '0;
            advance[N-1] = out_ready;
            load[N-1]    = !stage_valid[N-1] || out_ready;
            for (int k = N - 2; k >= 0; k--) begin
                advance[k] = load[k+1];
                load[k]    = !stage_valid[k] || advance[k];
            end
        end

        for (genvar k = 0; k < N; k++) begin : g_stage
            logic                 up_valid;
            logic [BIT_WIDTH-1:0] up_data;

            if (k == 0) begin : g_first
                assign up_valid = in_valid;
                assign up_data  = in_data;
            end else begin : g_next
                assign up_valid = stage_valid[k-1];
                assign up_data  = stage_data[k-1];
            end

            elastic_pipeline_stage #(
                .BIT_WIDTH  (BIT_WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk      (clk),
                .reset_n  (reset_n),
                .flush    (flush),
                .load     (load[k]),
                .up_valid (up_valid),
                .up_data  (up_data),
                .valid    (stage_valid[k]),
                .data     (stage_data[k])
            );
        end

        // Population count of the stage valid flops
        always_comb begin
            pop_count = '0;
            for (int i = 0; i < N; i++) begin
                pop_count = pop_count + OCC_W'(stage_valid[i]);
            end
        end

        assign in_ready  = load[0] && !flush;
        assign out_valid = stage_valid[N-1] && !flush;
        assign out_data  = stage_data[N-1];
        assign occupancy = pop_count;
    end

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb/tb_elastic_pipeline.sv - directed self-checking bench for elastic_pipeline
module tb_elastic_pipeline;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // N=3 instance
    logic       a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [7:0] a_in_data = 0, a_out_data;
    logic [1:0] a_occ;
    // N=4 instance
    logic       b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [7:0] b_in_data = 0, b_out_data;
    logic [2:0] b_occ;
    // N=0 instance
    logic       c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [7:0] c_in_data = 0, c_out_data;
    logic [0:0] c_occ;

    elastic_pipeline #(.BIT_WIDTH(8), .NUMBER_OF_STAGES(3), .RESET_DATA(1)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ));

    elastic_pipeline #(.BIT_WIDTH(8), .NUMBER_OF_STAGES(4), .RESET_DATA(1)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ));

    elastic_pipeline #(.BIT_WIDTH(8), .NUMBER_OF_STAGES(0), .RESET_DATA(1)) u_c (
        .clk(clk), .reset_n(reset_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 16'(a_out_valid), 16'h0);
        chk("rst_a_occ", 16'(a_occ), 16'h0);
        chk("rst_a_out_data", 16'(a_out_data), 16'h0);
        chk("rst_b_occ", 16'(b_occ), 16'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_a_in_ready", 16'(a_in_ready), 16'h1);
        chk("rst_b_in_ready", 16'(b_in_ready), 16'h1);

        // N=3 streaming, latency 3
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = 8'h11; step();
        chk("t1_e1_out_valid", 16'(a_out_valid), 16'h0);
        a_in_data = 8'h22; step();
        chk("t1_e2_out_valid", 16'(a_out_valid), 16'h0);
        a_in_data = 8'h33; step();
        a_in_valid = 0;
        chk("t1_e3_out_valid", 16'(a_out_valid), 16'h1);
        chk("t1_e3_out_data", 16'(a_out_data), 16'h11);
        chk("t1_e3_occ", 16'(a_occ), 16'h3);
        step();
        chk("t1_e4_out_data", 16'(a_out_data), 16'h22);
        chk("t1_e4_occ", 16'(a_occ), 16'h2);
        step();
        chk("t1_e5_out_valid", 16'(a_out_valid), 16'h1);
        chk("t1_e5_out_data", 16'(a_out_data), 16'h33);
        step();
        chk("t1_e6_out_valid", 16'(a_out_valid), 16'h0);
        chk("t1_e6_occ", 16'(a_occ), 16'h0);

        // N=3 backpressure, fill to capacity
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 8'hA0; step();
        a_in_data = 8'hA1; step();
        a_in_data = 8'hA2; step();
        a_in_data = 8'hA3; #1;
        chk("t2_full_in_ready", 16'(a_in_ready), 16'h0);
        chk("t2_full_occ", 16'(a_occ), 16'h3);
        step();
        chk("t2_hold_occ", 16'(a_occ), 16'h3);
        chk("t2_hold_out_data", 16'(a_out_data), 16'hA0);
        a_out_ready = 1; #1;
        chk("t2_pushpop_in_ready", 16'(a_in_ready), 16'h1);
        step();
        a_in_valid = 0;
        chk("t2_pushpop_occ", 16'(a_occ), 16'h3);
        chk("t2_d1", 16'(a_out_data), 16'hA1);
        step();
        chk("t2_d2", 16'(a_out_data), 16'hA2);
        step();
        chk("t2_d3", 16'(a_out_data), 16'hA3);
        chk("t2_d3_valid", 16'(a_out_valid), 16'h1);
        step();
        chk("t2_empty", 16'(a_out_valid), 16'h0);

        // N=4 bubble collapse under backpressure
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 8'h05; step();
        b_in_valid = 0; step();
        step();
        chk("t3_idle_in_ready", 16'(b_in_ready), 16'h1);
        b_in_valid = 1; b_in_data = 8'h06; step();
        b_in_valid = 0; step();
        step();
        chk("t3_occ", 16'(b_occ), 16'h2);
        chk("t3_in_ready", 16'(b_in_ready), 16'h1);
        chk("t3_out_valid", 16'(b_out_valid), 16'h1);
        chk("t3_out_data", 16'(b_out_data), 16'h05);
        b_out_ready = 1; step();
        chk("t3_second", 16'(b_out_data), 16'h06);
        chk("t3_second_valid", 16'(b_out_valid), 16'h1);
        step();
        chk("t3_drained", 16'(b_occ), 16'h0);

        // N=3 flush of a full pipeline
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 8'h01; step();
        a_in_data = 8'h02; step();
        a_in_data = 8'h03; step();
        chk("t4_full_occ", 16'(a_occ), 16'h3);
        a_in_data = 8'h04; a_out_ready = 1; a_flush = 1; #1;
        chk("t4_flush_in_ready", 16'(a_in_ready), 16'h0);
        chk("t4_flush_out_valid", 16'(a_out_valid), 16'h0);
        step();
        a_flush = 0; a_in_valid = 0; #1;
        chk("t4_post_occ", 16'(a_occ), 16'h0);
        chk("t4_post_out_valid", 16'(a_out_valid), 16'h0);
        a_in_valid = 1; a_in_data = 8'h55; step();
        a_in_valid = 0;
        chk("t4_new_e1", 16'(a_out_valid), 16'h0);
        step();
        chk("t4_new_e2", 16'(a_out_valid), 16'h0);
        step();
        chk("t4_new_valid", 16'(a_out_valid), 16'h1);
        chk("t4_new_data", 16'(a_out_data), 16'h55);
        step();
        chk("t4_new_gone", 16'(a_out_valid), 16'h0);

        // N=3 asynchronous reset mid-operation
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 8'h71; step();
        a_in_data = 8'h72; step();
        a_in_valid = 0; step();
        chk("t5_pre_occ", 16'(a_occ), 16'h2);
        chk("t5_pre_data", 16'(a_out_data), 16'h71);
        #1 reset_n = 0;
        #1;
        chk("t5_rst_out_valid", 16'(a_out_valid), 16'h0);
        chk("t5_rst_occ", 16'(a_occ), 16'h0);
        chk("t5_rst_out_data", 16'(a_out_data), 16'h0);
        #1 reset_n = 1;
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", 16'(a_out_valid), 16'h0);
        end

        // N=0 pass-through
        c_in_valid = 1; c_in_data = 8'h3C; c_out_ready = 0; #1;
        chk("t6_data", 16'(c_out_data), 16'h3C);
        chk("t6_out_valid", 16'(c_out_valid), 16'h1);
        chk("t6_in_ready_lo", 16'(c_in_ready), 16'h0);
        c_out_ready = 1; #1;
        chk("t6_in_ready_hi", 16'(c_in_ready), 16'h1);
        chk("t6_occ", 16'(c_occ), 16'h0);
        c_flush = 1; #1;
        chk("t6_flush_in_ready", 16'(c_in_ready), 16'h0);
        chk("t6_flush_out_valid", 16'(c_out_valid), 16'h0);
        c_flush = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
